// File: rtl/pcie_rx_avst_ingress_buf.sv
// RX ingress buffer between the PCIe HIP AVST RX port and the TLP checker.
// First-word-fall-through FIFO with ready-latency-aware backpressure and overflow/occupancy status.
module pcie_rx_avst_ingress_buf #(
  parameter int NUM_CH        = 2,
  parameter int CH_WIDTH      = 256,
  parameter int DEPTH_LOG2    = 8,
  parameter int READY_LATENCY = 20
) (
  input  logic                         avl_clk,
  input  logic                         avl_rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*CH_WIDTH-1:0]   in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [NUM_CH-1:0]            out_ch_valid,
  output logic [NUM_CH*CH_WIDTH-1:0]   out_data,
  input  logic                         out_ready,
  output logic [DEPTH_LOG2:0]          occupancy,
  output logic [DEPTH_LOG2:0]          hwm,
  input  logic                         hwm_clr,
  output logic                         ovf_err,
  output logic [15:0]                  ovf_cnt,
  input  logic                         err_clr
);

  localparam int DATA_W = NUM_CH * CH_WIDTH;
  localparam int BEAT_W = NUM_CH + DATA_W;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_THRESH = (DEPTH_LOG2 + 1)'(DEPTH - READY_LATENCY);

  if (READY_LATENCY >= DEPTH || READY_LATENCY < 0) begin : g_bad_ready_latency
    $error("READY_LATENCY must be in [0, 2**DEPTH_LOG2)");
  end
  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
    $error("NUM_CH must be in [1, 4]");
  end

  logic [BEAT_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   used;
  logic [DEPTH_LOG2:0]   used_next;
  logic [BEAT_W-1:0]     head;
  logic                  any_valid;
  logic                  full;
  logic                  wr;
  logic                  rd;
  logic                  drop;

  // A beat with no valid channel carries nothing, so it is neither stored nor counted as a drop.
  assign any_valid = |in_valid;
  assign full      = (used == DEPTH_CNT);
  assign wr        = any_valid && !full;
  assign drop      = any_valid && full;
  assign rd        = out_valid && out_ready;

  always_comb begin
    used_next = used;
    if (wr && !rd) used_next = used + 1'b1;
    if (!wr && rd) used_next = used - 1'b1;
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are live,
  // so clearing it would only add reset fan-out and block RAM inference.
  always_ff @(posedge avl_clk) begin
    if (wr) mem[wr_ptr] <= {in_valid, in_data};
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge avl_clk) begin
    if (!avl_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      used     <= '0;
      in_ready <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      used     <= used_next;
      // Leaves exactly READY_LATENCY free slots for beats already in flight from the HIP.
      in_ready <= (used_next < AF_THRESH);
    end
  end

  always_ff @(posedge avl_clk) begin
    if (!avl_rst_n) begin
      hwm <= '0;
    end else if (hwm_clr || (used_next > hwm)) begin
      hwm <= used_next;
    end
  end

  // A drop in the same cycle as err_clr must still be reported, so it restarts the count at 1.
  always_ff @(posedge avl_clk) begin
    if (!avl_rst_n) begin
      ovf_err <= 1'b0;
      ovf_cnt <= '0;
    end else if (drop) begin
      ovf_err <= 1'b1;
      if (err_clr)                  ovf_cnt <= 16'd1;
      else if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end else if (err_clr) begin
      ovf_err <= 1'b0;
      ovf_cnt <= '0;
    end
  end

  assign head         = mem[rd_ptr];
  assign out_valid    = (used != '0);
  assign out_data     = head[DATA_W-1:0];
  assign out_ch_valid = out_valid ? head[DATA_W +: NUM_CH] : '0;
  assign occupancy    = used;

endmodule

// File: tb/tb_pcie_rx_avst_ingress_buf.sv
// Self-checking bench: a queue-based reference model is compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_pcie_rx_avst_ingress_buf;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 16;
  localparam int DL2    = 4;
  localparam int RL     = 4;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - RL;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*CH_W-1:0]   in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [NUM_CH-1:0]        out_ch_valid;
  logic [NUM_CH*CH_W-1:0]   out_data;
  logic                     out_ready;
  logic [DL2:0]             occupancy;
  logic [DL2:0]             hwm;
  logic                     hwm_clr;
  logic                     ovf_err;
  logic [15:0]              ovf_cnt;
  logic                     err_clr;

  pcie_rx_avst_ingress_buf #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CH_W), .DEPTH_LOG2(DL2), .READY_LATENCY(RL)
  ) dut (
    .avl_clk(clk), .avl_rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ch_valid(out_ch_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy), .hwm(hwm), .hwm_clr(hwm_clr),
    .ovf_err(ovf_err), .ovf_cnt(ovf_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored beats plus status counters.
  typedef struct {
    logic [NUM_CH-1:0]      v;
    logic [NUM_CH*CH_W-1:0] d;
  } beat_t;

  beat_t       q[$];
  bit          m_on = 0;
  bit          m_ready;
  int          m_hwm;
  bit          m_err;
  int          m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_on = 1;
      m_ready = 0;
      m_hwm = 0;
      m_err = 0;
      m_cnt = 0;
    end else if (m_on) begin
      bit pop, push, drp;
      pop  = (q.size() != 0) && out_ready;
      push = (in_valid != 0) && (q.size() < DEPTH);
      drp  = (in_valid != 0) && (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{v: in_valid, d: in_data});
      m_ready = q.size() < AF;
      if (hwm_clr || q.size() > m_hwm) m_hwm = q.size();
      if (drp) begin
        m_err = 1;
        m_cnt = err_clr ? 1 : (m_cnt < 16'hFFFF ? m_cnt + 1 : m_cnt);
      end else if (err_clr) begin
        m_err = 0;
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("m_in_ready", in_ready, m_ready);
      check("m_out_valid", out_valid, q.size() != 0);
      check("m_occupancy", occupancy, q.size());
      check("m_hwm", hwm, m_hwm);
      check("m_ovf_err", ovf_err, m_err);
      check("m_ovf_cnt", ovf_cnt, m_cnt);
      if (q.size() != 0) begin
        check("m_out_ch_valid", out_ch_valid, q[0].v);
        check("m_out_data", out_data, q[0].d);
      end else begin
        check("m_out_ch_valid_idle", out_ch_valid, 0);
      end
    end
  end

  task automatic cyc(input logic [1:0] v, input logic [31:0] d, input logic ordy,
                     input logic hclr = 1'b0, input logic eclr = 1'b0);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    hwm_clr   = hclr;
    err_clr   = eclr;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t2_data [3];
  logic [1:0]  t2_v    [3];

  initial begin
    t2_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    t2_v    = '{2'b01, 2'b11, 2'b10};

    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0; hwm_clr = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);

    rst_n = 1'b1;
    cyc(2'b00, 0, 1'b0);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    cyc(2'b00, 0, 1'b0);

    // Three beats with mixed channel valids, then pop them back in order.
    for (int i = 0; i < 3; i++) cyc(t2_v[i], t2_data[i], 1'b0);
    check("t2_occupancy", occupancy, 3);
    check("t2_hwm", hwm, 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_head_v", out_ch_valid, t2_v[i]);
      check("t2_head_d", out_data, t2_data[i]);
      cyc(2'b00, 0, 1'b1);
    end
    check("t2_empty", out_valid, 0);
    check("t2_empty_chv", out_ch_valid, 0);

    // Fill to the almost-full threshold, then the ready-latency tail.
    for (int i = 0; i < 12; i++) begin
      if (i == 11) check("t3_ready_before", in_ready, 1);
      cyc(2'b11, 32'hC000_0000 + i, 1'b0);
    end
    check("t3_in_ready_low", in_ready, 0);
    check("t3_occ12", occupancy, 12);
    for (int i = 12; i < 16; i++) cyc(2'b11, 32'hC000_0000 + i, 1'b0);
    check("t3_occ16", occupancy, 16);
    check("t3_no_err", ovf_err, 0);

    // Drops while full; the pop in the third drop cycle frees a slot but takes no write.
    cyc(2'b01, 32'hDEAD_0000, 1'b0);
    cyc(2'b10, 32'hDEAD_0001, 1'b0);
    check("t4_head_oldest", out_data, 32'hC000_0000);
    cyc(2'b11, 32'hDEAD_0002, 1'b1);
    check("t4_ovf_cnt3", ovf_cnt, 3);
    check("t4_ovf_err", ovf_err, 1);
    check("t4_occ15", occupancy, 15);
    check("t4_next_head", out_data, 32'hC000_0001);
    cyc(2'b11, 32'hC000_0010, 1'b0);
    check("t4_refill", occupancy, 16);
    cyc(2'b01, 32'hDEAD_0003, 1'b0, 1'b0, 1'b1);
    check("t4_clr_drop_cnt", ovf_cnt, 1);
    check("t4_clr_drop_err", ovf_err, 1);
    cyc(2'b00, 0, 1'b0, 1'b0, 1'b1);
    check("t4_clr_cnt", ovf_cnt, 0);
    check("t4_clr_err", ovf_err, 0);

    // Drain to 5, then steady write+read across the pointer wrap.
    for (int i = 0; i < 11; i++) cyc(2'b00, 0, 1'b1);
    check("t5_occ5", occupancy, 5);
    check("t5_head", out_data, 32'hC000_000C);
    for (int i = 0; i < 20; i++) cyc(2'b11, 32'hE000_0000 + i, 1'b1);
    check("t5_occ_steady", occupancy, 5);
    check("t5_head_wrap", out_data, 32'hE000_000F);
    check("t5_hwm_kept", hwm, 16);
    cyc(2'b00, 0, 1'b0, 1'b1, 1'b0);
    check("t5_hwm_clr", hwm, 5);

    // Saturate the drop counter, then reset mid-stream.
    for (int i = 0; i < 11; i++) cyc(2'b11, 32'hF000_0000 + i, 1'b0);
    check("t6_full", occupancy, 16);
    for (int i = 0; i < 65540; i++) cyc(2'b01, i, 1'b0);
    check("t6_sat", ovf_cnt, 16'hFFFF);
    check("t6_err", ovf_err, 1);
    rst_n = 1'b0;
    cyc(2'b11, 32'h5555_5555, 1'b1);
    cyc(2'b11, 32'h6666_6666, 1'b1);
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_cnt", ovf_cnt, 0);
    check("t6_rst_err", ovf_err, 0);
    check("t6_rst_hwm", hwm, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 0);
    rst_n = 1'b1;
    cyc(2'b00, 0, 1'b1);
    check("t6_rel_ready", in_ready, 1);
    check("t6_rel_valid", out_valid, 0);
    cyc(2'b00, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_rx_avst_ingress_buf.md
# pcie_rx_avst_ingress_buf

Parametrised RX ingress buffer between the PCIe HIP AVST RX interface and the TLP checker, in the PCIe clock domain. It generalises the fixed two-channel RX FIFO to NUM_CH channels, configurable depth and ready latency. It computes ready-latency-aware backpressure in-block and adds sticky overflow reporting with a saturating drop counter and an occupancy high-watermark for the PCIe error/status CSRs.

## Interface
Parameters:
- NUM_CH, 2, AVST channels per beat (1..4)
- CH_WIDTH, 256, data+sideband bits per channel, excluding valid
- DEPTH_LOG2, 8, buffer depth = 2^DEPTH_LOG2 beats
- READY_LATENCY, 20, beats the source may still send after in_ready falls; must be < 2^DEPTH_LOG2 (elaboration error otherwise)

Ports:
- avl_clk  in  1  clock; the only clock
- avl_rst_n  in  1  reset, synchronous, active-low
- in_valid  in  NUM_CH  per-channel valid
- in_data  in  NUM_CH*CH_WIDTH  channel i at bits [i*CH_WIDTH +: CH_WIDTH]
- in_ready  out  1  registered backpressure to the HIP
- out_valid  out  1  buffer holds at least one beat
- out_ch_valid  out  NUM_CH  stored in_valid vector of the head beat, gated by out_valid
- out_data  out  NUM_CH*CH_WIDTH  head beat data
- out_ready  in  1  consumer accepts head beat
- occupancy  out  DEPTH_LOG2+1  beats stored
- hwm  out  DEPTH_LOG2+1  occupancy high-watermark
- hwm_clr  in  1  reload hwm with current occupancy
- ovf_err  out  1  sticky: beat dropped because the buffer was full
- ovf_cnt  out  16  dropped beats, saturating at 16'hFFFF
- err_clr  in  1  clear ovf_err and ovf_cnt

## Operation
- Write: wr = |in_valid && (used != DEPTH). Stores {in_valid, in_data} at wr_ptr; wr_ptr += 1. Beats with in_valid == 0 are never stored. in_ready is not part of the write qualification.
- Drop: |in_valid && used == DEPTH -> beat discarded, ovf_err <= 1, ovf_cnt += 1 (saturating). No write-through even when out_ready pops in the same cycle.
- Read: rd = out_valid && out_ready; rd_ptr += 1. out_valid = (used != 0). out_data/out_ch_valid are first-word-fall-through from mem[rd_ptr]; out_ch_valid = 0 when !out_valid.
- Count: used_next = used + wr - rd. Simultaneous wr and rd leave used unchanged. Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. occupancy = used.
- Backpressure: AF_THRESH = DEPTH - READY_LATENCY. in_ready <= (used_next < AF_THRESH). This guarantees no loss when the source honours READY_LATENCY.
- hwm: if hwm_clr then hwm <= used_next, else if used_next > hwm then hwm <= used_next.
- err_clr: ovf_err <= 0, ovf_cnt <= 0. If a drop occurs in the same cycle, the drop wins: ovf_err = 1, ovf_cnt = 1.
- Memory contents are not reset. Only pointers, counters and flags are reset.

## Timing
- Reset, avl_rst_n low at a clock edge: in_ready = 0, out_valid = 0, out_ch_valid = 0, occupancy = 0, hwm = 0, ovf_err = 0, ovf_cnt = 0, pointers = 0.
- in_ready rises on the first edge with avl_rst_n high.
- Reset mid-operation: all stored beats are discarded and no beat is emitted.
- Write-to-out_valid latency: 1 cycle. Beat written at edge N appears on out_* after edge N.
- Read-to-next-head: 0 extra cycles. Back-to-back pops at 1 beat/cycle are sustained.
- in_ready falls 1 cycle after used_next reaches AF_THRESH, and rises 1 cycle after used_next drops below it.
- ovf_err, ovf_cnt and hwm update at the edge of the causing event.

## Test plan
- Reset then idle, NUM_CH=2, DEPTH_LOG2=4, READY_LATENCY=4 -> all outputs 0 during reset. in_ready=1 on the first edge after release. out_valid stays 0.
- Write 3 beats with in_valid = 2'b01, 2'b11, 2'b10 and out_ready = 0 -> occupancy = 3 and hwm = 3. Popping yields the same data in order with out_ch_valid 01, 11, 10. out_valid falls after the 3rd pop.
- Stream writes, out_ready = 0, DEPTH = 16, AF_THRESH = 12 -> in_ready = 0 after occupancy reaches 12. Continue 4 more writes (READY_LATENCY) -> occupancy = 16, ovf_err = 0.
- At occupancy = 16, 3 more writes, one of them with out_ready = 1 -> all 3 dropped, ovf_cnt = 3, ovf_err = 1. The popped beat is the oldest, occupancy = 15. err_clr together with a 4th drop -> ovf_cnt = 1, ovf_err = 1.
- Simultaneous write and read at occupancy 5 for 20 cycles, including pointer wrap -> occupancy stays 5, data order preserved across the wrap. hwm_clr -> hwm = 5.
- Force 65540 drops -> ovf_cnt saturates at 16'hFFFF. Assert avl_rst_n low mid-stream -> all counters, flags and pointers return to 0.
